// File: rtl/trap_sequencer_pkg.sv
// Shared constants for the trap sequencer: PSW field positions, PSW write-source
// encodings, request/priority widths, FSM states and the handler address helper.
package trap_sequencer_pkg;

    localparam int unsigned PSW_WRITE_DATA_SOURCE_WIDTH = 2;
    localparam logic [PSW_WRITE_DATA_SOURCE_WIDTH-1:0] PSW_WRITE_DATA_SOURCE_MVTS          = 2'd0;
    localparam logic [PSW_WRITE_DATA_SOURCE_WIDTH-1:0] PSW_WRITE_DATA_SOURCE_HANDLER_ENTRY = 2'd1;
    localparam logic [PSW_WRITE_DATA_SOURCE_WIDTH-1:0] PSW_WRITE_DATA_SOURCE_HANDLER_EXIT  = 2'd2;

    localparam int unsigned PSW_V_BIT        = 27;
    localparam int unsigned PSW_IEN_BIT      = 23;
    localparam int unsigned PSW_PRIORITY_MSB = 20;
    localparam int unsigned PSW_PRIORITY_LSB = 16;
    localparam int unsigned PSW_MASK_MSB     = 15;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned IRQ_COUNT      = 16;
    localparam int unsigned REQUEST_WIDTH  = 32;
    localparam int unsigned PRIORITY_WIDTH = 5;

    typedef enum logic [1:0] {
        STATE_IDLE     = 2'd0,
        STATE_ENTRY    = 2'd1,
        STATE_REDIRECT = 2'd2,
        STATE_EXIT     = 2'd3
    } trapState_t;

    // Handler vector: base chosen by PSW V, plus the fixed handler offset.
    function automatic logic [DATA_WIDTH-1:0] handlerAddress(
        input logic                  vFlag,
        input logic [DATA_WIDTH-1:0] baseV0,
        input logic [DATA_WIDTH-1:0] baseV1,
        input logic [DATA_WIDTH-1:0] offset
    );
        return (vFlag ? baseV1 : baseV0) + offset;
    endfunction

endpackage

// File: rtl/trap_priority_encoder.sv
// Combinational 32-to-5 highest-set-bit encoder with an any-valid flag.
module trap_priority_encoder
    import trap_sequencer_pkg::*;
(
    input  logic [REQUEST_WIDTH-1:0]  requests,
    output logic [PRIORITY_WIDTH-1:0] highestIndex_c,
    output logic                      anyValid_c
);

    always_comb begin
        highestIndex_c = '0;
        anyValid_c     = |requests;
        for (int i = 0; i < REQUEST_WIDTH; i++) begin
            if (requests[i]) begin
                highestIndex_c = PRIORITY_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// Sequences PSW handler entry (interrupts/exceptions) and exit (RFX), and
// hands the handler vector to instruction fetch.
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int unsigned          SYNC_STAGES    = 2,
    parameter logic [DATA_WIDTH-1:0] VECTOR_BASE_V0 = 32'hE0000000,
    parameter logic [DATA_WIDTH-1:0] VECTOR_BASE_V1 = 32'hC0000000,
    parameter logic [DATA_WIDTH-1:0] HANDLER_OFFSET = 32'h00000004
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [DATA_WIDTH-1:0]                  pswValue,
    input  logic [IRQ_COUNT-1:0]                   irq,
    input  logic                                   instructionBoundary,
    input  logic                                   excValid,
    input  logic [PRIORITY_WIDTH-1:0]              excCode,
    input  logic                                   rfxRequest,
    output logic                                   pswWriteEnable,
    output logic [PSW_WRITE_DATA_SOURCE_WIDTH-1:0] pswWriteDataSource,
    output logic [PRIORITY_WIDTH-1:0]              pswPriorityWriteValue,
    output logic                                   excAck,
    output logic                                   rfxDone,
    output logic                                   redirectValid,
    output logic [DATA_WIDTH-1:0]                  redirectAddress,
    input  logic                                   redirectReady,
    output logic                                   busy
);

    localparam int unsigned SYNC_DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    trapState_t                           state;
    logic [SYNC_DEPTH-1:0][IRQ_COUNT-1:0] irqSync;
    logic [IRQ_COUNT-1:0]                 irqEligible;
    logic [REQUEST_WIDTH-1:0]             requestVector;
    logic [PRIORITY_WIDTH-1:0]            winnerIndex;
    logic                                 anyRequest;
    logic                                 unusedPswBits;

    assign irqEligible = irqSync[SYNC_DEPTH-1]
                       & pswValue[PSW_MASK_MSB:0]
                       & {IRQ_COUNT{pswValue[PSW_IEN_BIT]}};

    // PSW fields this block never consumes (priority is written, not read).
    assign unusedPswBits = ^{pswValue[31:28], pswValue[26:24], pswValue[22:16]};

    // Exceptions sit at their code position (16..31) so they outrank every IRQ.
    always_comb begin
        requestVector = REQUEST_WIDTH'(irqEligible);
        if (excValid) begin
            requestVector[excCode] = 1'b1;
        end
    end

    trap_priority_encoder u_priorityEncoder (
        .requests      (requestVector),
        .highestIndex_c(winnerIndex),
        .anyValid_c    (anyRequest)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state                 <= STATE_IDLE;
            irqSync               <= '0;
            pswWriteEnable        <= 1'b0;
            pswWriteDataSource    <= PSW_WRITE_DATA_SOURCE_HANDLER_ENTRY;
            pswPriorityWriteValue <= '0;
            excAck                <= 1'b0;
            rfxDone               <= 1'b0;
            redirectValid         <= 1'b0;
            redirectAddress       <= '0;
            busy                  <= 1'b0;
        end else begin
            irqSync               <= {irqSync[SYNC_DEPTH-2:0], irq};
            pswWriteEnable        <= 1'b0;
            pswWriteDataSource    <= PSW_WRITE_DATA_SOURCE_HANDLER_ENTRY;
            pswPriorityWriteValue <= '0;
            excAck                <= 1'b0;
            rfxDone               <= 1'b0;

            case (state)
                STATE_IDLE: begin
                    if (excValid) begin
                        state                 <= STATE_ENTRY;
                        pswWriteEnable        <= 1'b1;
                        pswPriorityWriteValue <= winnerIndex;
                        excAck                <= 1'b1;
                        busy                  <= 1'b1;
                    end else if (rfxRequest) begin
                        state              <= STATE_EXIT;
                        pswWriteEnable     <= 1'b1;
                        pswWriteDataSource <= PSW_WRITE_DATA_SOURCE_HANDLER_EXIT;
                        rfxDone            <= 1'b1;
                        busy               <= 1'b1;
                    end else if (anyRequest && instructionBoundary) begin
                        state                 <= STATE_ENTRY;
                        pswWriteEnable        <= 1'b1;
                        pswPriorityWriteValue <= winnerIndex;
                        busy                  <= 1'b1;
                    end
                end
                // V is not touched by entry, so the vector can be sampled here.
                STATE_ENTRY: begin
                    state           <= STATE_REDIRECT;
                    redirectValid   <= 1'b1;
                    redirectAddress <= handlerAddress(pswValue[PSW_V_BIT], VECTOR_BASE_V0,
                                                      VECTOR_BASE_V1, HANDLER_OFFSET);
                end
                STATE_REDIRECT: begin
                    if (redirectReady) begin
                        state           <= STATE_IDLE;
                        redirectValid   <= 1'b0;
                        redirectAddress <= '0;
                        busy            <= 1'b0;
                    end
                end
                STATE_EXIT: begin
                    state <= STATE_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= STATE_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: a per-cycle vector table for the basic IRQ
// entry/redirect flow, then hand-written multi-cycle sequences.
module tb_trap_sequencer;
    import trap_sequencer_pkg::*;

    localparam logic [1:0] SRC_ENTRY = PSW_WRITE_DATA_SOURCE_HANDLER_ENTRY;
    localparam logic [1:0] SRC_EXIT  = PSW_WRITE_DATA_SOURCE_HANDLER_EXIT;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pswValue = '0;
    logic [15:0] irq = '0;
    logic        instructionBoundary = 1'b0;
    logic        excValid = 1'b0;
    logic [4:0]  excCode = '0;
    logic        rfxRequest = 1'b0;
    logic        redirectReady = 1'b0;
    logic        pswWriteEnable;
    logic [1:0]  pswWriteDataSource;
    logic [4:0]  pswPriorityWriteValue;
    logic        excAck;
    logic        rfxDone;
    logic        redirectValid;
    logic [31:0] redirectAddress;
    logic        busy;

    int checks = 0;
    int errors = 0;

    trap_sequencer dut (
        .clock                (clock),
        .reset                (reset),
        .pswValue             (pswValue),
        .irq                  (irq),
        .instructionBoundary  (instructionBoundary),
        .excValid             (excValid),
        .excCode              (excCode),
        .rfxRequest           (rfxRequest),
        .pswWriteEnable       (pswWriteEnable),
        .pswWriteDataSource   (pswWriteDataSource),
        .pswPriorityWriteValue(pswPriorityWriteValue),
        .excAck               (excAck),
        .rfxDone              (rfxDone),
        .redirectValid        (redirectValid),
        .redirectAddress      (redirectAddress),
        .redirectReady        (redirectReady),
        .busy                 (busy)
    );

    always #5 clock = ~clock;

    // {we, src, prio, excAck, rfxDone, redirectValid, redirectAddress, busy}
    typedef struct {
        logic        rst;
        logic [31:0] psw;
        logic [15:0] irqLines;
        logic        boundary;
        logic        ready;
        logic [43:0] expected;
    } vec_t;

    function automatic logic [43:0] packOut(input logic we, input logic [1:0] src, input logic [4:0] prio,
                                            input logic ack, input logic done, input logic rv,
                                            input logic [31:0] addr, input logic bsy);
        return {we, src, prio, ack, done, rv, addr, bsy};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic waitForWrite(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (pswWriteEnable === 1'b1) seen = 1'b1;
        end
    endtask

    vec_t vecs[8];
    bit   seen;

    initial begin
        logic [43:0] idleOut;
        idleOut = packOut(1'b0, SRC_ENTRY, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

        // IRQ 5 through 2 sync stages, entry on 3rd edge, redirect held one extra cycle.
        vecs[0] = '{1'b0, 32'h0, 16'h0000, 1'b0, 1'b0, idleOut};
        vecs[1] = '{1'b1, 32'h00800020, 16'h0020, 1'b1, 1'b0, idleOut};
        vecs[2] = '{1'b1, 32'h00800020, 16'h0020, 1'b1, 1'b0, idleOut};
        vecs[3] = '{1'b1, 32'h00800020, 16'h0020, 1'b1, 1'b0,
                    packOut(1'b1, SRC_ENTRY, 5'd5, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1)};
        vecs[4] = '{1'b1, 32'h00800020, 16'h0000, 1'b1, 1'b0,
                    packOut(1'b0, SRC_ENTRY, 5'd0, 1'b0, 1'b0, 1'b1, 32'hE0000004, 1'b1)};
        vecs[5] = '{1'b1, 32'h00800020, 16'h0000, 1'b1, 1'b0,
                    packOut(1'b0, SRC_ENTRY, 5'd0, 1'b0, 1'b0, 1'b1, 32'hE0000004, 1'b1)};
        vecs[6] = '{1'b1, 32'h00800020, 16'h0000, 1'b1, 1'b1, idleOut};
        vecs[7] = '{1'b1, 32'h00800020, 16'h0000, 1'b1, 1'b1, idleOut};

        for (int i = 0; i < 8; i++) begin
            reset               = vecs[i].rst;
            pswValue            = vecs[i].psw;
            irq                 = vecs[i].irqLines;
            instructionBoundary = vecs[i].boundary;
            redirectReady       = vecs[i].ready;
            tick();
            check($sformatf("vec%0d", i),
                  {20'd0, pswWriteEnable, pswWriteDataSource, pswPriorityWriteValue, excAck,
                   rfxDone, redirectValid, redirectAddress, busy},
                  {20'd0, vecs[i].expected});
        end

        // IEN=0 blocks the IRQ; an exception is still taken.
        pswValue = 32'h00000020;
        irq = 16'h0020;
        instructionBoundary = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("ien0_no_write", pswWriteEnable, 1'b0);
        end
        excValid = 1'b1;
        excCode = 5'd20;
        tick();
        check("exc20_we", pswWriteEnable, 1'b1);
        check("exc20_ack", excAck, 1'b1);
        check("exc20_prio", pswPriorityWriteValue, 5'd20);
        check("exc20_src", pswWriteDataSource, SRC_ENTRY);
        excValid = 1'b0;
        tick();
        check("exc20_ack_pulse", excAck, 1'b0);
        check("exc20_redirect", {redirectValid, redirectAddress}, {1'b1, 32'hE0000004});
        irq = 16'h0000;
        for (int i = 0; i < 3; i++) tick();
        check("exc20_idle", busy, 1'b0);

        // Mask selects between IRQ 12 and IRQ 3.
        pswValue = 32'h00801008;
        irq = 16'h1008;
        waitForWrite(6, seen);
        check("mask_first_write", seen, 1'b1);
        check("mask_prio12", pswPriorityWriteValue, 5'd12);
        pswValue = 32'h00800008;
        waitForWrite(6, seen);
        check("mask_second_write", seen, 1'b1);
        check("mask_prio3", pswPriorityWriteValue, 5'd3);
        irq = 16'h0000;
        instructionBoundary = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mask_idle", busy, 1'b0);

        // RFX beats a simultaneous eligible IRQ; IRQ follows only once re-enabled.
        pswValue = 32'h00800080;
        irq = 16'h0080;
        for (int i = 0; i < 3; i++) tick();
        check("rfx_pre_no_write", pswWriteEnable, 1'b0);
        rfxRequest = 1'b1;
        instructionBoundary = 1'b1;
        tick();
        check("rfx_exit", {pswWriteEnable, pswWriteDataSource, rfxDone}, {1'b1, SRC_EXIT, 1'b1});
        rfxRequest = 1'b0;
        pswValue = 32'h00000080;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rfx_restored_ien0", pswWriteEnable, 1'b0);
        end
        check("rfx_done_pulse", rfxDone, 1'b0);
        pswValue = 32'h00800080;
        waitForWrite(4, seen);
        check("rfx_then_irq", seen, 1'b1);
        check("rfx_irq_prio7", {pswWriteDataSource, pswPriorityWriteValue}, {SRC_ENTRY, 5'd7});
        irq = 16'h0000;
        instructionBoundary = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("rfx_idle", busy, 1'b0);

        // V=1 vector, fetch stalls 3 cycles.
        redirectReady = 1'b0;
        pswValue = 32'h08800000;
        excValid = 1'b1;
        excCode = 5'd17;
        tick();
        check("v1_entry", {pswWriteEnable, excAck, pswPriorityWriteValue}, {1'b1, 1'b1, 5'd17});
        excValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("v1_hold%0d", i), {pswWriteEnable, redirectValid, redirectAddress},
                  {1'b0, 1'b1, 32'hC0000004});
            if (i == 3) redirectReady = 1'b1;
        end
        tick();
        check("v1_released", {redirectValid, busy}, 2'b00);

        // Reset during REDIRECT abandons the operation.
        redirectReady = 1'b0;
        pswValue = 32'h00000000;
        excValid = 1'b1;
        excCode = 5'd25;
        tick();
        check("rst_entry_prio", pswPriorityWriteValue, 5'd25);
        excValid = 1'b0;
        tick();
        check("rst_in_redirect", redirectValid, 1'b1);
        reset = 1'b0;
        tick();
        check("rst_outputs",
              {20'd0, pswWriteEnable, pswWriteDataSource, pswPriorityWriteValue, excAck,
               rfxDone, redirectValid, redirectAddress, busy},
              {20'd0, idleOut});
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_no_write", {pswWriteEnable, busy}, 2'b00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
